// File: rtl/bike_pkg.sv
// Shared bike-computer divider definitions: default operand/result widths and the
// one-hot FSM encoding used by div_arbiter and its requesters.
package bike_pkg;

  localparam int unsigned DefDividendWidth = 20;
  localparam int unsigned DefDivisorWidth  = 14;
  localparam int unsigned DefResultWidth   = 12;
  localparam int unsigned DefTimeout       = 64;

  localparam logic [3:0] StIdleEnc  = 4'b0001;
  localparam logic [3:0] StIssueEnc = 4'b0010;
  localparam logic [3:0] StWaitEnc  = 4'b0100;
  localparam logic [3:0] StRespEnc  = 4'b1000;

  typedef enum logic [3:0] {
    StIdle  = StIdleEnc,
    StIssue = StIssueEnc,
    StWait  = StWaitEnc,
    StResp  = StRespEnc
  } div_state_e;

  // Requester indices: bit 0 of a request/grant vector is spd, bit 1 is avg.
  localparam logic ReqSpd = 1'b0;
  localparam logic ReqAvg = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer to the requester favoured on
// the next tie, advanced only when the grant is accepted.
module rr_arb2
  import bike_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_ack,
  output logic [1:0] o_gnt
);

  logic r_prio;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio <= ReqSpd;
    end else if (i_ack) begin
      // Serving spd hands the next tie to avg and vice versa.
      r_prio <= o_gnt[0];
    end
  end

  always_comb begin
    o_gnt = i_req;
    if (&i_req) begin
      o_gnt = (r_prio == ReqAvg) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one external divider between the speed and average-speed requesters.
// Optional WAIT timeout is built only when DIV_TIMEOUT_EN is defined.
module div_arbiter
  import bike_pkg::*;
#(
  parameter int unsigned DIVIDEND_WIDTH = DefDividendWidth,
  parameter int unsigned DIVISOR_WIDTH  = DefDivisorWidth,
  parameter int unsigned RESULT_WIDTH   = DefResultWidth,
  parameter int unsigned TIMEOUT        = DefTimeout
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      spd_req,
  input  logic [DIVIDEND_WIDTH-1:0] spd_dividend,
  input  logic [DIVISOR_WIDTH-1:0]  spd_divisor,
  output logic                      spd_gnt,
  output logic [RESULT_WIDTH-1:0]   spd_result,
  output logic                      spd_valid,
  input  logic                      avg_req,
  input  logic [DIVIDEND_WIDTH-1:0] avg_dividend,
  input  logic [DIVISOR_WIDTH-1:0]  avg_divisor,
  output logic                      avg_gnt,
  output logic [RESULT_WIDTH-1:0]   avg_result,
  output logic                      avg_valid,
  output logic                      err,
  output logic                      div_start,
  output logic [DIVIDEND_WIDTH-1:0] div_dividend,
  output logic [DIVISOR_WIDTH-1:0]  div_divisor,
  input  logic [DIVIDEND_WIDTH-1:0] div_quotient,
  input  logic                      div_valid
);

  div_state_e                r_state;
  div_state_e                w_state_next;
  logic [1:0]                w_req;
  logic [1:0]                w_arb_gnt;
  logic                      w_sel_avg;
  logic [DIVIDEND_WIDTH-1:0] w_sel_dividend;
  logic [DIVISOR_WIDTH-1:0]  w_sel_divisor;
  logic                      w_load;
  logic                      w_div_start;
  logic                      w_timeout;
  logic                      w_over;
  logic                      w_sat;
  logic [RESULT_WIDTH-1:0]   w_result;

  logic                      r_owner;
  logic                      r_abort;
  logic [DIVIDEND_WIDTH-1:0] r_dividend;
  logic [DIVISOR_WIDTH-1:0]  r_divisor;
  logic [DIVIDEND_WIDTH-1:0] r_quot;
  logic                      r_spd_gnt;
  logic                      r_avg_gnt;
  logic                      r_spd_valid;
  logic                      r_avg_valid;
  logic                      r_err;
  logic [RESULT_WIDTH-1:0]   r_spd_result;
  logic [RESULT_WIDTH-1:0]   r_avg_result;

  assign w_req = {avg_req, spd_req};

  rr_arb2 u_rr_arb2 (
    .i_clk (clock),
    .i_rst (reset),
    .i_req (w_req),
    .i_ack (w_load),
    .o_gnt (w_arb_gnt)
  );

  assign w_sel_avg      = w_arb_gnt[1];
  assign w_sel_dividend = w_sel_avg ? avg_dividend : spd_dividend;
  assign w_sel_divisor  = w_sel_avg ? avg_divisor : spd_divisor;

`ifdef DIV_TIMEOUT_EN
  localparam int unsigned TmoCntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TmoCntW-1:0] r_tmo_cnt;

  always_ff @(posedge clock) begin
    if (reset || (r_state != StWait)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Abort is decided in the last WAIT cycle so *_valid lands TIMEOUT cycles after WAIT entry.
  assign w_timeout = (r_state == StWait) && (r_tmo_cnt == TmoCntW'(TIMEOUT - 2));
`else
  assign w_timeout = 1'b0;
`endif

  // FSM: state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (|w_req) begin
          w_state_next = (w_sel_divisor == '0) ? StResp : StIssue;
        end
      end
      StIssue: w_state_next = StWait;
      StWait: begin
        if (div_valid || w_timeout) begin
          w_state_next = StResp;
        end
      end
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM: outputs and result saturation.
  always_comb begin
    w_load      = (r_state == StIdle) && (|w_req);
    w_div_start = (r_state == StIssue);
    w_over      = (r_quot >> RESULT_WIDTH) != '0;
    w_sat       = r_abort || w_over;
    w_result    = w_sat ? '1 : r_quot[RESULT_WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner      <= ReqSpd;
      r_abort      <= 1'b0;
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_quot       <= '0;
      r_spd_gnt    <= 1'b0;
      r_avg_gnt    <= 1'b0;
      r_spd_valid  <= 1'b0;
      r_avg_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_spd_result <= '0;
      r_avg_result <= '0;
    end else begin
      r_spd_gnt   <= w_load && w_arb_gnt[0];
      r_avg_gnt   <= w_load && w_arb_gnt[1];
      r_spd_valid <= 1'b0;
      r_avg_valid <= 1'b0;
      r_err       <= 1'b0;
      if (w_load) begin
        r_owner    <= w_sel_avg;
        r_dividend <= w_sel_dividend;
        r_divisor  <= w_sel_divisor;
        r_abort    <= (w_sel_divisor == '0);
      end
      if (r_state == StWait) begin
        if (div_valid) begin
          r_quot <= div_quotient;
        end else if (w_timeout) begin
          r_abort <= 1'b1;
        end
      end
      if (r_state == StResp) begin
        r_err <= w_sat;
        if (r_owner == ReqAvg) begin
          r_avg_valid  <= 1'b1;
          r_avg_result <= w_result;
        end else begin
          r_spd_valid  <= 1'b1;
          r_spd_result <= w_result;
        end
      end
    end
  end

  assign spd_gnt      = r_spd_gnt;
  assign avg_gnt      = r_avg_gnt;
  assign spd_valid    = r_spd_valid;
  assign avg_valid    = r_avg_valid;
  assign spd_result   = r_spd_result;
  assign avg_result   = r_avg_result;
  assign err          = r_err;
  assign div_start    = w_div_start;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed and random transactions checked against a
// behavioural model of arbitration order, latency and result saturation.
module tb_div_arbiter;

  localparam int unsigned DW  = 20;
  localparam int unsigned VW  = 14;
  localparam int unsigned RW  = 12;
  localparam int unsigned TMO = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          spd_req, avg_req;
  logic [DW-1:0] spd_dividend, avg_dividend;
  logic [VW-1:0] spd_divisor, avg_divisor;
  logic          spd_gnt, avg_gnt, spd_valid, avg_valid, err, div_start;
  logic [RW-1:0] spd_result, avg_result;
  logic [DW-1:0] div_dividend, div_quotient;
  logic [VW-1:0] div_divisor;
  logic          div_valid;

  div_arbiter #(
    .DIVIDEND_WIDTH (DW),
    .DIVISOR_WIDTH  (VW),
    .RESULT_WIDTH   (RW),
    .TIMEOUT        (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .spd_req      (spd_req),
    .spd_dividend (spd_dividend),
    .spd_divisor  (spd_divisor),
    .spd_gnt      (spd_gnt),
    .spd_result   (spd_result),
    .spd_valid    (spd_valid),
    .avg_req      (avg_req),
    .avg_dividend (avg_dividend),
    .avg_divisor  (avg_divisor),
    .avg_gnt      (avg_gnt),
    .avg_result   (avg_result),
    .avg_valid    (avg_valid),
    .err          (err),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_valid    (div_valid)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errs   = 0;
  bit m_prio   = 1'b0;  // requester favoured on the next tie: 0 = spd, 1 = avg

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errs++;
      $error("FAIL %s: observed=%0d required=%0d", tag, obs, want);
    end
  endtask

  function automatic logic [DW-1:0] model_quot(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs,
                                               input bit use_fq, input logic [DW-1:0] fq);
    if (use_fq) return fq;
    if (dvs == '0) return '1;
    return dvd / DW'(dvs);
  endfunction

  // {err, result} a requester must see for a given quotient.
  function automatic logic [RW:0] model_resp(input bit dz, input logic [DW-1:0] q);
    if (dz || (q > DW'((1 << RW) - 1))) return {1'b1, {RW{1'b1}}};
    return {1'b0, q[RW-1:0]};
  endfunction

  function automatic logic [VW-1:0] rand_divisor();
    int k = $urandom_range(0, 9);
    if (k < 2) return '0;
    if (k < 5) return VW'($urandom_range(1, 255));
    return VW'($urandom_range(1, (1 << VW) - 1));
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "/spd_gnt"}, spd_gnt, 0);
    check({tag, "/avg_gnt"}, avg_gnt, 0);
    check({tag, "/spd_valid"}, spd_valid, 0);
    check({tag, "/avg_valid"}, avg_valid, 0);
    check({tag, "/err"}, err, 0);
    check({tag, "/div_start"}, div_start, 0);
    check({tag, "/spd_result"}, spd_result, 0);
    check({tag, "/avg_result"}, avg_result, 0);
    check({tag, "/div_dividend"}, div_dividend, 0);
    check({tag, "/div_divisor"}, div_divisor, 0);
  endtask

  // One arbitration episode: the enabled requesters raise req together in cycle 0.
  task automatic run(input bit en_s, input bit en_a,
                     input logic [DW-1:0] s_dvd, input logic [VW-1:0] s_dvs,
                     input logic [DW-1:0] a_dvd, input logic [VW-1:0] a_dvs,
                     input int lat, input bit use_fq, input logic [DW-1:0] fq,
                     input string tag);
    bit            en [2];
    logic [DW-1:0] dvd [2];
    logic [VW-1:0] dvs [2];
    int            order [$];
    int            exp_st [$];
    int            exp_gnt [2], exp_val [2];
    logic [RW:0]   exp_rsp [2];
    logic [RW-1:0] held [2];
    int            gnt_n [2], gnt_c [2], val_n [2], val_c [2];
    logic [RW-1:0] val_res [2];
    logic          val_err [2];
    logic [DW-1:0] st_dvd [$];
    logic [VW-1:0] st_dvs [$];
    int            overlap, pend_c, done_c, t, p;
    logic [DW-1:0] pend_q;
    string         pn [2];

    pn[0] = "spd"; pn[1] = "avg";
    en[0] = en_s;  en[1] = en_a;
    dvd[0] = s_dvd; dvd[1] = a_dvd;
    dvs[0] = s_dvs; dvs[1] = a_dvs;
    held[0] = spd_result; held[1] = avg_result;
    for (int i = 0; i < 2; i++) begin
      gnt_n[i] = 0; gnt_c[i] = -1; val_n[i] = 0; val_c[i] = -1;
      val_res[i] = '0; val_err[i] = 1'b0; exp_gnt[i] = -1; exp_val[i] = -1;
      exp_rsp[i] = model_resp(dvs[i] == '0, model_quot(dvd[i], dvs[i], use_fq, fq));
    end

    if (en[0] && en[1]) begin
      order.push_back(int'(m_prio));
      order.push_back(1 - int'(m_prio));
    end else begin
      order.push_back(en[1] ? 1 : 0);
    end
    m_prio = (order[order.size() - 1] == 0);

    t = 0;
    foreach (order[k]) begin
      p = order[k];
      exp_gnt[p] = t + 1;
      exp_val[p] = t + ((dvs[p] == '0) ? 2 : 3 + lat);
      t = exp_val[p];
      if (dvs[p] != '0) exp_st.push_back(p);
    end
    done_c = t + 4;

    spd_req = en_s; spd_dividend = s_dvd; spd_divisor = s_dvs;
    avg_req = en_a; avg_dividend = a_dvd; avg_divisor = a_dvs;
    overlap = 0;
    pend_c = -1;
    pend_q = '0;

    for (int c = 1; c <= done_c; c++) begin
      tick();
      if (spd_gnt && avg_gnt) overlap++;
      if (spd_valid && avg_valid) overlap++;
      if (spd_gnt) begin gnt_n[0]++; gnt_c[0] = c; spd_req = 1'b0; end
      if (avg_gnt) begin gnt_n[1]++; gnt_c[1] = c; avg_req = 1'b0; end
      if (div_start) begin
        st_dvd.push_back(div_dividend);
        st_dvs.push_back(div_divisor);
        pend_c = c + lat;
        pend_q = model_quot(div_dividend, div_divisor, use_fq, fq);
      end
      if (spd_valid) begin val_n[0]++; val_c[0] = c; val_res[0] = spd_result; val_err[0] = err; end
      if (avg_valid) begin val_n[1]++; val_c[1] = c; val_res[1] = avg_result; val_err[1] = err; end
      div_valid    = (c == pend_c);
      div_quotient = (c == pend_c) ? pend_q : DW'($urandom);
    end
    spd_req = 1'b0;
    avg_req = 1'b0;
    div_valid = 1'b0;

    for (int i = 0; i < 2; i++) begin
      if (en[i]) begin
        check($sformatf("%s/%s_gnt_count", tag, pn[i]), gnt_n[i], 1);
        check($sformatf("%s/%s_gnt_cycle", tag, pn[i]), gnt_c[i], exp_gnt[i]);
        check($sformatf("%s/%s_valid_count", tag, pn[i]), val_n[i], 1);
        check($sformatf("%s/%s_valid_cycle", tag, pn[i]), val_c[i], exp_val[i]);
        check($sformatf("%s/%s_result", tag, pn[i]), val_res[i], exp_rsp[i][RW-1:0]);
        check($sformatf("%s/%s_err", tag, pn[i]), val_err[i], exp_rsp[i][RW]);
        check($sformatf("%s/%s_result_held", tag, pn[i]),
              (i == 0) ? spd_result : avg_result, exp_rsp[i][RW-1:0]);
      end else begin
        check($sformatf("%s/%s_gnt_count", tag, pn[i]), gnt_n[i], 0);
        check($sformatf("%s/%s_valid_count", tag, pn[i]), val_n[i], 0);
        check($sformatf("%s/%s_result_untouched", tag, pn[i]),
              (i == 0) ? spd_result : avg_result, held[i]);
      end
    end
    check($sformatf("%s/div_start_count", tag), st_dvd.size(), exp_st.size());
    foreach (exp_st[k]) begin
      if (k < st_dvd.size()) begin
        check($sformatf("%s/div_dividend%0d", tag, k), st_dvd[k], dvd[exp_st[k]]);
        check($sformatf("%s/div_divisor%0d", tag, k), st_dvs[k], dvs[exp_st[k]]);
      end
    end
    check($sformatf("%s/pulse_overlap", tag), overlap, 0);
  endtask

  initial begin
    int            n_stale, n_v, v_c;
    logic [RW-1:0] v_res;
    logic          v_err;
    bit            es, ea;
    logic [DW-1:0] sd, ad;
    logic [VW-1:0] sv, av;

    reset = 1'b1;
    spd_req = 1'b0; spd_dividend = '0; spd_divisor = '0;
    avg_req = 1'b0; avg_dividend = '0; avg_divisor = '0;
    div_quotient = '0; div_valid = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    reset = 1'b0;

    // First tie after reset goes to spd; each result reaches only its own port.
    run(1, 1, 20'd50000, 14'd7, 20'd30000, 14'd300, 3, 0, '0, "tie");
    run(1, 0, 20'd36000, 14'd1000, '0, '0, 5, 0, '0, "spd_basic");
    run(0, 1, '0, '0, 20'd12345, 14'd0, 4, 0, '0, "avg_div0");
    run(1, 0, 20'd1000, 14'd1, '0, '0, 2, 1, 20'd5000, "sat5000");
    run(0, 1, '0, '0, 20'd8190, 14'd2, 2, 1, 20'd4095, "q4095");
    run(1, 1, 20'd99, 14'd0, 20'd77, 14'd0, 1, 0, '0, "both_div0");

    for (int i = 0; i < 40; i++) begin
      es = 1'($urandom_range(0, 1));
      ea = 1'($urandom_range(0, 1));
      if (!es && !ea) es = 1'b1;
      sd = DW'($urandom);
      ad = DW'($urandom);
      sv = rand_divisor();
      av = rand_divisor();
      run(es, ea, sd, sv, ad, av, $urandom_range(1, 8), 0, '0, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset while WAITing, then a stale div_valid: nothing may come out.
    spd_req = 1'b1; spd_dividend = 20'd1000; spd_divisor = 14'd10;
    tick();
    spd_req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    div_quotient = 20'd100;
    div_valid = 1'b1;
    n_stale = 0;
    tick();
    div_valid = 1'b0;
    if (spd_valid || avg_valid) n_stale++;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (spd_valid || avg_valid || spd_gnt || avg_gnt || div_start) n_stale++;
    end
    check("rst_mid/activity", n_stale, 0);
    check_idle("rst_mid");
    m_prio = 1'b0;
    run(1, 1, 20'd4000, 14'd4, 20'd9000, 14'd3, 2, 0, '0, "post_rst_tie");

    // Divider never answers.
    spd_req = 1'b1; spd_dividend = 20'd777; spd_divisor = 14'd3;
    n_v = 0; v_c = -1; v_res = '0; v_err = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (spd_gnt) spd_req = 1'b0;
      if (spd_valid || avg_valid) begin
        n_v++;
        if (v_c < 0) begin v_c = c; v_res = spd_result; v_err = err; end
      end
    end
`ifdef DIV_TIMEOUT_EN
    check("timeout/valid_count", n_v, 1);
    check("timeout/valid_cycle", v_c, 2 + TMO);
    check("timeout/result", v_res, (1 << RW) - 1);
    check("timeout/err", v_err, 1);
`else
    check("no_timeout/valid_count", n_v, 0);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check_idle("final_reset");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
